ls1u_bus_arbiter: RTL and testbench

- Two-requester arbiter in front of the single AHB bus_unit. It shares the unit between the CPU L1 cache-controller port and the cDMA engine port.
- Each requester presents the bus_unit request interface: write-through, single read, line read, pa, write data. The arbiter muxes the granted requester onto bus_unit and routes completion and read data back.
- CPU has fixed priority. A starvation counter guarantees the DMA port forward progress.
- Instantiated between the L1/cDMA logic and bus_unit when cDMA_ENABLE=1.

---
 rtl/ls1u_bus_pkg.sv | 16 +
 rtl/ls1u_starve_cnt.sv | 31 +++
 rtl/ls1u_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_ls1u_bus_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls1u_bus_pkg.sv
// Shared types and helpers for the L1/cDMA bus_unit arbiter.
package ls1u_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_CPU  = 2'b01,
        ARB_DMA  = 2'b10
    } arb_state_e;

    localparam int CNT_W = 8;

    function automatic logic req_valid(input logic wt_any, input logic rd, input logic rdl);
        return wt_any | rd | rdl;
    endfunction

endpackage

// File: rtl/ls1u_starve_cnt.sv
// Saturating wait counter: counts cycles a DMA request loses, flags when it must win.
module ls1u_starve_cnt
    import ls1u_bus_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;

    // Clear beats increment: the clearing cycle also has a pending DMA request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (inc && (wait_cnt != MAX_CNT)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign sat = (wait_cnt == MAX_CNT);

endmodule

// File: rtl/ls1u_bus_arbiter.sv
// Fixed-priority CPU/DMA arbiter in front of bus_unit, with a DMA starvation guard.
module ls1u_bus_arbiter
    import ls1u_bus_pkg::*;
#(
    parameter int BUS_ADDR     = 32,
    parameter int BUS_WIDTH    = 16,
    parameter int DMA_MAX_WAIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BUS_WIDTH/8-1:0] c_wt_req,
    input  logic                   c_rd_req,
    input  logic                   c_rdl_req,
    input  logic [BUS_ADDR-1:0]    c_pa,
    input  logic [BUS_WIDTH-1:0]   c_wdata,
    output logic                   c_rdy,
    output logic                   c_err,
    input  logic [BUS_WIDTH/8-1:0] d_wt_req,
    input  logic                   d_rd_req,
    input  logic                   d_rdl_req,
    input  logic [BUS_ADDR-1:0]    d_pa,
    input  logic [BUS_WIDTH-1:0]   d_wdata,
    output logic                   d_rdy,
    output logic                   d_err,
    output logic [BUS_WIDTH/8-1:0] m_wt_req,
    output logic                   m_rd_req,
    output logic                   m_rdl_req,
    output logic [BUS_ADDR-1:0]    m_pa,
    output logic [BUS_WIDTH-1:0]   m_wdata,
    input  logic                   m_rdy,
    input  logic                   m_err,
    input  logic [BUS_WIDTH-1:0]   m_rdata,
    output logic [BUS_WIDTH-1:0]   c_rdata,
    output logic [BUS_WIDTH-1:0]   d_rdata,
    output logic                   gnt_cpu,
    output logic                   gnt_dma
);

    arb_state_e state;
    arb_state_e state_nxt;
    logic       c_req;
    logic       d_req;
    logic       starve;
    logic       done;

    assign c_req = req_valid(|c_wt_req, c_rd_req, c_rdl_req);
    assign d_req = req_valid(|d_wt_req, d_rd_req, d_rdl_req);
    assign done  = m_rdy | m_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A grant is held until bus_unit completes, even if the owner drops its request.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (starve && d_req) begin
                    state_nxt = ARB_DMA;
                end else if (c_req) begin
                    state_nxt = ARB_CPU;
                end else if (d_req) begin
                    state_nxt = ARB_DMA;
                end
            end
            ARB_CPU, ARB_DMA: begin
                if (done) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    ls1u_starve_cnt #(
        .MAX_WAIT(DMA_MAX_WAIT)
    ) u_starve_cnt (
        .clk(clk),
        .rst(rst),
        .inc(d_req && (state != ARB_DMA)),
        .clr((state == ARB_IDLE) && (state_nxt == ARB_DMA)),
        .sat(starve)
    );

    assign gnt_cpu = (state == ARB_CPU);
    assign gnt_dma = (state == ARB_DMA);

    // Mux selects only on registered state, so requests never reach m_* in the same cycle.
    always_comb begin
        m_wt_req  = '0;
        m_rd_req  = 1'b0;
        m_rdl_req = 1'b0;
        m_pa      = '0;
        m_wdata   = '0;
        if (gnt_cpu) begin
            m_wt_req  = c_wt_req;
            m_rd_req  = c_rd_req;
            m_rdl_req = c_rdl_req;
            m_pa      = c_pa;
            m_wdata   = c_wdata;
        end else if (gnt_dma) begin
            m_wt_req  = d_wt_req;
            m_rd_req  = d_rd_req;
            m_rdl_req = d_rdl_req;
            m_pa      = d_pa;
            m_wdata   = d_wdata;
        end
    end

    assign c_rdy   = gnt_cpu & m_rdy;
    assign c_err   = gnt_cpu & m_err;
    assign d_rdy   = gnt_dma & m_rdy;
    assign d_err   = gnt_dma & m_err;
    assign c_rdata = m_rdata;
    assign d_rdata = m_rdata;

endmodule

// File: tb/tb_ls1u_bus_arbiter.sv
// Bench for ls1u_bus_arbiter: behavioural owner/wait model checked every cycle, plus directed literal checks.
module tb_ls1u_bus_arbiter;

    localparam int BA   = 32;
    localparam int BW   = 16;
    localparam int LN   = BW / 8;
    localparam int MAXW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [LN-1:0] c_wt_req, d_wt_req, m_wt_req;
    logic          c_rd_req, c_rdl_req, d_rd_req, d_rdl_req, m_rd_req, m_rdl_req;
    logic [BA-1:0] c_pa, d_pa, m_pa;
    logic [BW-1:0] c_wdata, d_wdata, m_wdata, m_rdata, c_rdata, d_rdata;
    logic          c_rdy, c_err, d_rdy, d_err, m_rdy, m_err, gnt_cpu, gnt_dma;

    int checks = 0;
    int errors = 0;

    // Model: owner 0 = none, 1 = CPU, 2 = DMA; mw = cycles the DMA has lost.
    int mo = 0;
    int mw = 0;

    ls1u_bus_arbiter #(.BUS_ADDR(BA), .BUS_WIDTH(BW), .DMA_MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .c_wt_req(c_wt_req), .c_rd_req(c_rd_req), .c_rdl_req(c_rdl_req),
        .c_pa(c_pa), .c_wdata(c_wdata), .c_rdy(c_rdy), .c_err(c_err),
        .d_wt_req(d_wt_req), .d_rd_req(d_rd_req), .d_rdl_req(d_rdl_req),
        .d_pa(d_pa), .d_wdata(d_wdata), .d_rdy(d_rdy), .d_err(d_err),
        .m_wt_req(m_wt_req), .m_rd_req(m_rd_req), .m_rdl_req(m_rdl_req),
        .m_pa(m_pa), .m_wdata(m_wdata), .m_rdy(m_rdy), .m_err(m_err),
        .m_rdata(m_rdata), .c_rdata(c_rdata), .d_rdata(d_rdata),
        .gnt_cpu(gnt_cpu), .gnt_dma(gnt_dma)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic bit creq_f();
        return (c_wt_req != 0) || c_rd_req || c_rdl_req;
    endfunction

    function automatic bit dreq_f();
        return (d_wt_req != 0) || d_rd_req || d_rdl_req;
    endfunction

    function automatic int next_owner(int o, int w, bit cr, bit dr, bit dn);
        if (o == 0) begin
            if (w == MAXW && dr) return 2;
            if (cr) return 1;
            if (dr) return 2;
            return 0;
        end
        return dn ? 0 : o;
    endfunction

    function automatic int next_wait(int o, int w, bit cr, bit dr);
        if (o == 0 && next_owner(o, w, cr, dr, 1'b0) == 2) return 0;
        if (dr && o != 2) return (w < MAXW) ? w + 1 : MAXW;
        return w;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mo <= 0;
            mw <= 0;
        end else begin
            mo <= next_owner(mo, mw, creq_f(), dreq_f(), m_rdy || m_err);
            mw <= next_wait(mo, mw, creq_f(), dreq_f());
        end
    end

    always @(negedge clk) begin
        chk("m_wt_req",  64'(m_wt_req),  64'(mo == 1 ? c_wt_req  : mo == 2 ? d_wt_req  : '0));
        chk("m_rd_req",  64'(m_rd_req),  64'(mo == 1 ? c_rd_req  : mo == 2 ? d_rd_req  : 1'b0));
        chk("m_rdl_req", 64'(m_rdl_req), 64'(mo == 1 ? c_rdl_req : mo == 2 ? d_rdl_req : 1'b0));
        chk("m_pa",      64'(m_pa),      64'(mo == 1 ? c_pa      : mo == 2 ? d_pa      : '0));
        chk("m_wdata",   64'(m_wdata),   64'(mo == 1 ? c_wdata   : mo == 2 ? d_wdata   : '0));
        chk("gnt_cpu",   64'(gnt_cpu),   64'(mo == 1));
        chk("gnt_dma",   64'(gnt_dma),   64'(mo == 2));
        chk("c_rdy",     64'(c_rdy),     64'(mo == 1 && m_rdy));
        chk("c_err",     64'(c_err),     64'(mo == 1 && m_err));
        chk("d_rdy",     64'(d_rdy),     64'(mo == 2 && m_rdy));
        chk("d_err",     64'(d_err),     64'(mo == 2 && m_err));
        chk("c_rdata",   64'(c_rdata),   64'(m_rdata));
        chk("d_rdata",   64'(d_rdata),   64'(m_rdata));
    end

    task automatic clear_inputs();
        c_wt_req = '0; c_rd_req = 1'b0; c_rdl_req = 1'b0; c_pa = '0; c_wdata = '0;
        d_wt_req = '0; d_rd_req = 1'b0; d_rdl_req = 1'b0; d_pa = '0; d_wdata = '0;
        m_rdy = 1'b0; m_err = 1'b0; m_rdata = '0;
    endtask

    // Leaves the caller at posedge+1 with reset released: that cycle is "cycle 0".
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic new_cpu_req();
        int kind;
        kind = $urandom_range(0, 2);
        c_wt_req  = (kind == 0) ? LN'($urandom_range(1, (1 << LN) - 1)) : '0;
        c_rd_req  = (kind == 1);
        c_rdl_req = (kind == 2);
        c_pa      = BA'($urandom);
        c_wdata   = BW'($urandom);
    endtask

    task automatic new_dma_req();
        int kind;
        kind = $urandom_range(0, 2);
        d_wt_req  = (kind == 0) ? LN'($urandom_range(1, (1 << LN) - 1)) : '0;
        d_rd_req  = (kind == 1);
        d_rdl_req = (kind == 2);
        d_pa      = BA'($urandom);
        d_wdata   = BW'($urandom);
    endtask

    task automatic rand_phase(input int n);
        bit c_done, d_done, busy;
        int lat, r;
        busy = 1'b0;
        lat  = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c_done = (mo == 1) && (m_rdy || m_err);
            d_done = (mo == 2) && (m_rdy || m_err);
            @(posedge clk);
            #1;
            if (c_done) begin
                if ($urandom_range(0, 3) == 0) new_cpu_req();
                else begin c_wt_req = '0; c_rd_req = 1'b0; c_rdl_req = 1'b0; end
            end else if (!creq_f() && $urandom_range(0, 2) == 0) begin
                new_cpu_req();
            end
            if (d_done) begin
                if ($urandom_range(0, 3) == 0) new_dma_req();
                else begin d_wt_req = '0; d_rd_req = 1'b0; d_rdl_req = 1'b0; end
            end else if (!dreq_f() && $urandom_range(0, 2) == 0) begin
                new_dma_req();
            end
            m_rdata = BW'($urandom);
            m_rdy   = 1'b0;
            m_err   = 1'b0;
            if (mo != 0) begin
                if (!busy) begin
                    busy = 1'b1;
                    lat  = $urandom_range(0, 3);
                end
                if (lat == 0) begin
                    r     = $urandom_range(0, 7);
                    m_err = (r == 0);
                    m_rdy = (r != 0);
                end else begin
                    lat--;
                end
            end else begin
                busy  = 1'b0;
                m_rdy = ($urandom_range(0, 15) == 0);
                m_err = ($urandom_range(0, 31) == 0);
            end
        end
    endtask

    initial begin
        int gc_cnt, first_dma;
        bit gc[12];
        bit gd[12];
        clear_inputs();
        #3;
        chk("reset gnt_cpu", 64'(gnt_cpu), 64'd0);
        chk("reset gnt_dma", 64'(gnt_dma), 64'd0);
        chk("reset m_pa",    64'(m_pa),    64'd0);

        // CPU-only single read
        do_reset();
        c_rd_req = 1'b1;
        c_pa     = 32'h0001_0040;
        next_cycle();
        chk("cpu gnt_cpu c1",  64'(gnt_cpu),  64'd1);
        chk("cpu m_rd_req c1", 64'(m_rd_req), 64'd1);
        chk("cpu m_pa c1",     64'(m_pa),     64'h0001_0040);
        next_cycle();
        next_cycle();
        @(posedge clk);
        #1 m_rdy = 1'b1;
        @(negedge clk);
        chk("cpu c_rdy c4", 64'(c_rdy), 64'd1);
        chk("cpu d_rdy c4", 64'(d_rdy), 64'd0);
        @(posedge clk);
        #1 m_rdy = 1'b0;
        c_rd_req = 1'b0;
        @(negedge clk);
        chk("cpu gnt_cpu c5",  64'(gnt_cpu),  64'd0);
        chk("cpu m_rd_req c5", 64'(m_rd_req), 64'd0);

        // Simultaneous requests, then DMA error and a stray m_rdy in IDLE
        do_reset();
        c_rdl_req = 1'b1;
        d_wt_req  = 2'b11;
        d_wdata   = 16'hA5C3;
        d_pa      = 32'h0000_2000;
        next_cycle();
        chk("sim gnt_cpu c1",   64'(gnt_cpu),   64'd1);
        chk("sim m_rdl_req c1", 64'(m_rdl_req), 64'd1);
        @(posedge clk);
        #1 m_rdy = 1'b1;
        @(negedge clk);
        chk("sim c_rdy c2", 64'(c_rdy), 64'd1);
        @(posedge clk);
        #1 m_rdy = 1'b0;
        c_rdl_req = 1'b0;
        @(negedge clk);
        chk("sim idle gnt_dma c3", 64'(gnt_dma), 64'd0);
        @(posedge clk);
        #1 m_err = 1'b1;
        @(negedge clk);
        chk("sim gnt_dma c4",  64'(gnt_dma),  64'd1);
        chk("sim m_wt_req c4", 64'(m_wt_req), 64'd3);
        chk("sim m_wdata c4",  64'(m_wdata),  64'hA5C3);
        chk("err d_err c4",    64'(d_err),    64'd1);
        chk("err c_err c4",    64'(c_err),    64'd0);
        @(posedge clk);
        #1 m_err = 1'b0;
        m_rdy    = 1'b1;
        d_wt_req = '0;
        @(negedge clk);
        chk("err d_err c5",   64'(d_err),   64'd0);
        chk("stray c_rdy c5", 64'(c_rdy),   64'd0);
        chk("stray d_rdy c5", 64'(d_rdy),   64'd0);
        chk("err gnt_dma c5", 64'(gnt_dma), 64'd0);
        @(posedge clk);
        #1 m_rdy = 1'b0;

        // Starvation: both ports request continuously, bus completes every granted cycle
        do_reset();
        c_rd_req = 1'b1;
        c_pa     = 32'h0000_1000;
        d_rd_req = 1'b1;
        d_pa     = 32'h0000_3000;
        m_rdy    = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            next_cycle();
            gc[i] = gnt_cpu;
            gd[i] = gnt_dma;
        end
        gc_cnt    = 0;
        first_dma = 0;
        for (int i = 1; i <= 11; i++) begin
            if (i <= 8 && gc[i]) gc_cnt++;
            if (gd[i] && first_dma == 0) first_dma = i;
        end
        chk("starve cpu grants", 64'(gc_cnt),    64'd4);
        chk("starve first dma",  64'(first_dma), 64'd9);
        chk("starve cpu c11",    64'(gc[11]),    64'd1);
        @(posedge clk);
        #1 clear_inputs();

        // Reset mid-transfer, CPU request kept high across it
        do_reset();
        c_rd_req = 1'b1;
        c_pa     = 32'h0000_0400;
        next_cycle();
        chk("rst gnt_cpu before", 64'(gnt_cpu), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst m_rd_req async", 64'(m_rd_req), 64'd0);
        chk("rst gnt_cpu async",  64'(gnt_cpu),  64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst idle c0", 64'(gnt_cpu), 64'd0);
        next_cycle();
        chk("rst regrant c1", 64'(gnt_cpu), 64'd1);
        @(posedge clk);
        #1 m_rdy = 1'b1;
        @(negedge clk);
        chk("rst c_rdy", 64'(c_rdy), 64'd1);
        @(posedge clk);
        #1 clear_inputs();

        do_reset();
        rand_phase(4000);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
